// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register-map controller.
package i2c_pkg;

    localparam int unsigned DEF_NUM_REGS = 16;
    localparam logic [6:0]  DEF_DEV_ADDR = 7'h50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TXN,
        ST_GET_PTR,
        ST_RX_DATA,
        ST_TX_DATA
    } state_t;

endpackage

// File: rtl/i2c_reg_bank.sv
// NUM_REGS x 8 register bank: I2C write port A beats host write port B,
// two registered read ports (transmit pointer and host address).
module i2c_reg_bank
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             a_we_i,
    input  logic [PTR_W-1:0] a_addr_i,
    input  logic [7:0]       a_wdata_i,
    input  logic             b_we_i,
    input  logic [PTR_W-1:0] b_addr_i,
    input  logic [7:0]       b_wdata_i,
    input  logic [PTR_W-1:0] rd_tx_addr_i,
    input  logic [PTR_W-1:0] rd_host_addr_i,
    output logic [7:0]       rd_tx_data_o,
    output logic [7:0]       rd_host_data_o,
    output logic             collision_o
);

    logic [7:0] mem_q [NUM_REGS];
    logic [7:0] rd_tx_q;
    logic [7:0] rd_host_q;
    logic       collision_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end else if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Reads sample the array before this edge's write, so a write shows up
    // on the read ports exactly one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_tx_q     <= '0;
            rd_host_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            rd_tx_q     <= mem_q[rd_tx_addr_i];
            rd_host_q   <= mem_q[rd_host_addr_i];
            collision_q <= a_we_i & b_we_i;
        end
    end

    assign rd_tx_data_o   = rd_tx_q;
    assign rd_host_data_o = rd_host_q;
    assign collision_o    = collision_q;

endmodule

// File: rtl/i2c_slave_reg_controller.sv
// Register-map controller for the I2C slave byte engine: pointer/write FSM,
// transfer edge detection and a host-shared register bank.
module i2c_slave_reg_controller
    import i2c_pkg::*;
#(
    parameter int         NUM_REGS = DEF_NUM_REGS,
    parameter int         PTR_W    = $clog2(NUM_REGS),
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter bit         WRAP     = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic             slv_enable,
    output logic [6:0]       slv_address,
    output logic [7:0]       slv_data_write,
    input  logic [7:0]       slv_data_read,
    input  logic             slv_rw_flag,
    input  logic             slv_data_finish,
    input  logic             slv_transfer,
    input  logic             slv_error,
    input  logic [PTR_W-1:0] host_addr,
    input  logic             host_we,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_collision,
    output logic             reg_wr_pulse,
    output logic [PTR_W-1:0] reg_wr_index,
    output logic [PTR_W-1:0] ptr,
    output logic             bad_byte
);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             bad_q, bad_d;
    logic             wr_en;
    logic             xfer_q;
    logic             xfer_start, xfer_end;
    logic             slv_enable_q;
    logic             reg_wr_pulse_q;
    logic [PTR_W-1:0] reg_wr_index_q;
    logic             unused_rd_bits;

    assign unused_rd_bits = ^slv_data_read;

    function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
        if (!WRAP && p == PTR_W'(NUM_REGS - 1)) return p;
        return p + PTR_W'(1);
    endfunction

    assign xfer_start = slv_transfer & ~xfer_q;
    assign xfer_end   = ~slv_transfer & xfer_q;

    // xfer_q resets high so a transfer already running at reset release is
    // not mistaken for a fresh start; the controller waits for the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            bad_q          <= 1'b0;
            xfer_q         <= 1'b1;
            slv_enable_q   <= 1'b0;
            reg_wr_pulse_q <= 1'b0;
            reg_wr_index_q <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            bad_q          <= bad_d;
            xfer_q         <= slv_transfer;
            slv_enable_q   <= enable;
            reg_wr_pulse_q <= wr_en;
            reg_wr_index_q <= ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bad_d   = bad_q;
        wr_en   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_WAIT_TXN;
                ST_WAIT_TXN: begin
                    if (xfer_start) begin
                        bad_d   = 1'b0;
                        state_d = slv_rw_flag ? ST_GET_PTR : ST_TX_DATA;
                    end
                end
                ST_GET_PTR: begin
                    if (slv_data_finish) begin
                        if (slv_error) bad_d = 1'b1;
                        else           ptr_d = slv_data_read[PTR_W-1:0];
                        state_d = ST_RX_DATA;
                    end
                    if (xfer_end) state_d = ST_WAIT_TXN;
                end
                ST_RX_DATA: begin
                    if (slv_data_finish) begin
                        if (slv_error) begin
                            bad_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            ptr_d = adv(ptr_q);
                        end
                    end
                    if (xfer_end) state_d = ST_WAIT_TXN;
                end
                ST_TX_DATA: begin
                    if (slv_data_finish) ptr_d = adv(ptr_q);
                    if (xfer_end) state_d = ST_WAIT_TXN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    i2c_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W)
    ) u_bank (
        .clock          (clock),
        .reset          (reset),
        .a_we_i         (wr_en),
        .a_addr_i       (ptr_q),
        .a_wdata_i      (slv_data_read),
        .b_we_i         (host_we),
        .b_addr_i       (host_addr),
        .b_wdata_i      (host_wdata),
        .rd_tx_addr_i   (ptr_q),
        .rd_host_addr_i (host_addr),
        .rd_tx_data_o   (slv_data_write),
        .rd_host_data_o (host_rdata),
        .collision_o    (host_collision)
    );

    assign slv_enable   = slv_enable_q;
    assign slv_address  = DEV_ADDR;
    assign reg_wr_pulse = reg_wr_pulse_q;
    assign reg_wr_index = reg_wr_index_q;
    assign ptr          = ptr_q;
    assign bad_byte     = bad_q;

endmodule

// File: tb/tb_i2c_slave_reg_controller.sv
// Directed bench: WRAP=1 and WRAP=0 instances share stimulus; bank contents
// are observed through the host read port.
module tb_i2c_slave_reg_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] slv_data_read = '0;
    logic       slv_rw_flag = 1'b0;
    logic       slv_data_finish = 1'b0;
    logic       slv_transfer = 1'b0;
    logic       slv_error = 1'b0;
    logic [3:0] host_addr = '0;
    logic       host_we = 1'b0;
    logic [7:0] host_wdata = '0;

    logic       slv_enable, host_collision, reg_wr_pulse, bad_byte;
    logic [6:0] slv_address;
    logic [7:0] slv_data_write, host_rdata;
    logic [3:0] reg_wr_index, ptr;

    logic       w0_slv_enable, w0_host_collision, w0_reg_wr_pulse, w0_bad_byte;
    logic [6:0] w0_slv_address;
    logic [7:0] w0_slv_data_write, w0_host_rdata;
    logic [3:0] w0_reg_wr_index, w0_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    i2c_slave_reg_controller dut (
        .clock(clock), .reset(reset), .enable(enable),
        .slv_enable(slv_enable), .slv_address(slv_address),
        .slv_data_write(slv_data_write), .slv_data_read(slv_data_read),
        .slv_rw_flag(slv_rw_flag), .slv_data_finish(slv_data_finish),
        .slv_transfer(slv_transfer), .slv_error(slv_error),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_collision(host_collision),
        .reg_wr_pulse(reg_wr_pulse), .reg_wr_index(reg_wr_index),
        .ptr(ptr), .bad_byte(bad_byte)
    );

    i2c_slave_reg_controller #(.WRAP(1'b0)) dut_w0 (
        .clock(clock), .reset(reset), .enable(enable),
        .slv_enable(w0_slv_enable), .slv_address(w0_slv_address),
        .slv_data_write(w0_slv_data_write), .slv_data_read(slv_data_read),
        .slv_rw_flag(slv_rw_flag), .slv_data_finish(slv_data_finish),
        .slv_transfer(slv_transfer), .slv_error(slv_error),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(w0_host_rdata), .host_collision(w0_host_collision),
        .reg_wr_pulse(w0_reg_wr_pulse), .reg_wr_index(w0_reg_wr_index),
        .ptr(w0_ptr), .bad_byte(w0_bad_byte)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_xfer(input logic rw);
        slv_rw_flag  = rw;
        slv_transfer = 1'b1;
        tick();
    endtask

    task automatic stop_xfer();
        slv_transfer = 1'b0;
        tick(2);
    endtask

    // One finished byte; outputs are sampled by the caller just after the edge.
    task automatic send_byte(input logic [7:0] d, input logic err);
        slv_data_read   = d;
        slv_error       = err;
        slv_data_finish = 1'b1;
        tick();
        slv_data_finish = 1'b0;
        slv_error       = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a);
        host_addr = a;
        tick();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_ptr", 32'(ptr), 32'h0);
        chk("rst_addr", 32'(slv_address), 32'h50);
        chk("rst_dw", 32'(slv_data_write), 32'h0);
        chk("rst_en", 32'(slv_enable), 32'h0);
        chk("rst_flags", 32'({reg_wr_pulse, host_collision, bad_byte}), 32'h0);
        tick(2);
        reset  = 1'b0;
        enable = 1'b1;
        tick(2);
        chk("slv_enable", 32'(slv_enable), 32'h1);

        // 1: write transfer 03, AA, BB
        start_xfer(1'b1);
        send_byte(8'h03, 1'b0);
        chk("t1_ptr_set", 32'(ptr), 32'h3);
        chk("t1_no_pulse", 32'(reg_wr_pulse), 32'h0);
        send_byte(8'hAA, 1'b0);
        chk("t1_pulse0", 32'({reg_wr_pulse, reg_wr_index}), 32'h13);
        chk("t1_ptr4", 32'(ptr), 32'h4);
        tick();
        chk("t1_pulse_end", 32'(reg_wr_pulse), 32'h0);
        send_byte(8'hBB, 1'b0);
        chk("t1_pulse1", 32'({reg_wr_pulse, reg_wr_index}), 32'h14);
        chk("t1_ptr5", 32'(ptr), 32'h5);
        stop_xfer();
        host_read(4'd3);
        chk("t1_bank3", 32'(host_rdata), 32'hAA);
        host_read(4'd4);
        chk("t1_bank4", 32'(host_rdata), 32'hBB);

        // 2: set pointer to 3, then read back AA, BB
        start_xfer(1'b1);
        send_byte(8'h03, 1'b0);
        stop_xfer();
        start_xfer(1'b0);
        chk("t2_dw0", 32'(slv_data_write), 32'hAA);
        send_byte(8'h00, 1'b0);
        tick();
        chk("t2_dw1", 32'(slv_data_write), 32'hBB);
        send_byte(8'h00, 1'b0);
        chk("t2_ptr", 32'(ptr), 32'h5);
        stop_xfer();
        chk("t2_ptr_kept", 32'(ptr), 32'h5);

        // 3: pointer 0x0F (upper nibble ignored), write 11, 22
        start_xfer(1'b1);
        send_byte(8'hFF, 1'b0);
        chk("t3_ptr_f", 32'(ptr), 32'hF);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        stop_xfer();
        chk("t3_w1_ptr", 32'(ptr), 32'h1);
        chk("t3_w0_ptr", 32'(w0_ptr), 32'hF);
        host_read(4'd15);
        chk("t3_w1_b15", 32'(host_rdata), 32'h11);
        chk("t3_w0_b15", 32'(w0_host_rdata), 32'h22);
        host_read(4'd0);
        chk("t3_w1_b0", 32'(host_rdata), 32'h22);
        chk("t3_w0_b0", 32'(w0_host_rdata), 32'h00);

        // 4: host write collides with I2C write to reg 2
        start_xfer(1'b1);
        send_byte(8'h02, 1'b0);
        host_addr  = 4'd7;
        host_wdata = 8'h55;
        host_we    = 1'b1;
        send_byte(8'h66, 1'b0);
        host_we = 1'b0;
        chk("t4_coll", 32'(host_collision), 32'h1);
        tick();
        chk("t4_coll_end", 32'(host_collision), 32'h0);
        stop_xfer();
        host_read(4'd2);
        chk("t4_bank2", 32'(host_rdata), 32'h66);
        host_read(4'd7);
        chk("t4_bank7", 32'(host_rdata), 32'h00);
        host_addr  = 4'd9;
        host_wdata = 8'h5A;
        host_we    = 1'b1;
        tick();
        host_we = 1'b0;
        chk("t4_no_coll", 32'(host_collision), 32'h0);
        tick();
        chk("t4_host_wr", 32'(host_rdata), 32'h5A);

        // 5: data byte with slave error
        start_xfer(1'b1);
        send_byte(8'h06, 1'b0);
        send_byte(8'h77, 1'b1);
        chk("t5_no_pulse", 32'(reg_wr_pulse), 32'h0);
        chk("t5_ptr", 32'(ptr), 32'h6);
        chk("t5_bad", 32'(bad_byte), 32'h1);
        stop_xfer();
        chk("t5_bad_sticky", 32'(bad_byte), 32'h1);
        host_read(4'd6);
        chk("t5_bank6", 32'(host_rdata), 32'h00);
        start_xfer(1'b1);
        chk("t5_bad_clr", 32'(bad_byte), 32'h0);
        stop_xfer();

        // 6: asynchronous reset mid RX byte
        start_xfer(1'b1);
        send_byte(8'h04, 1'b0);
        send_byte(8'h12, 1'b0);
        host_addr     = 4'd4;
        slv_data_read = 8'h99;
        tick();
        chk("t6_pre_bank4", 32'(host_rdata), 32'h12);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_ptr", 32'(ptr), 32'h0);
        chk("t6_rst_dw", 32'(slv_data_write), 32'h0);
        chk("t6_rst_hr", 32'(host_rdata), 32'h0);
        chk("t6_rst_en", 32'(slv_enable), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_bank4_clr", 32'(host_rdata), 32'h00);
        send_byte(8'h99, 1'b0);
        tick();
        chk("t6_ignored", 32'({reg_wr_pulse, ptr}), 32'h0);
        stop_xfer();
        start_xfer(1'b1);
        send_byte(8'h03, 1'b0);
        send_byte(8'hAA, 1'b0);
        chk("t6_pulse0", 32'({reg_wr_pulse, reg_wr_index}), 32'h13);
        send_byte(8'hBB, 1'b0);
        chk("t6_ptr5", 32'(ptr), 32'h5);
        stop_xfer();
        host_read(4'd3);
        chk("t6_bank3", 32'(host_rdata), 32'hAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
